bpu_resolve: RTL and testbench

//  Execute-side counterpart of the next-PC predictor: takes up to two resolved branches per cycle, compares

---
 rtl/bpu_resolve_pkg.sv | 38 +++
 rtl/bpu_resolve_lane_check.sv | 31 +++
 rtl/bpu_resolve.sv | 147 ++++++++++++++
 tb/tb_bpu_resolve.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_resolve_pkg.sv
// Shared pipeline header for the branch predictor: prediction/correction
// bundles and target-type encodings.
package bpu_resolve_pkg;

  localparam int GHR_W  = 8;
  localparam int LPHR_W = 2;
  localparam int RAS_W  = 3;

  localparam logic [1:0] _BPU_TARGET_NPC    = 2'd0;
  localparam logic [1:0] _BPU_TARGET_CALL   = 2'd1;
  localparam logic [1:0] _BPU_TARGET_RETURN = 2'd2;
  localparam logic [1:0] _BPU_TARGET_IMM    = 2'd3;

  typedef struct packed {
    logic              taken;
    logic [31:0]       target;
    logic [GHR_W-1:0]  history;
    logic [LPHR_W-1:0] lphr;
    logic [RAS_W-1:0]  ras_ptr;
  } bpu_predict_t;

  typedef struct packed {
    logic              miss;
    logic [31:0]       pc;
    logic              true_taken;
    logic              true_dir;
    logic [1:0]        true_target_type;
    logic [31:0]       true_target;
    logic [GHR_W-1:0]  history;
    logic [LPHR_W-1:0] lphr;
    logic [RAS_W-1:0]  ras_ptr;
  } bpu_correct_t;

  function automatic logic [31:0] pc_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/bpu_resolve_lane_check.sv
// One resolved lane: actual direction, correct-path PC and whether the
// prediction fetched with it was wrong.
module bpu_lane_check
  import bpu_resolve_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_pred_taken,
  input  logic [31:0] i_pred_target,
  input  logic        i_is_branch,
  input  logic        i_taken,
  input  logic [1:0]  i_target_type,
  input  logic [31:0] i_target,
  output logic        o_miss,
  output logic        o_act_taken,
  output logic [31:0] o_true_target,
  output logic [1:0]  o_true_type
);

  logic w_dir_miss;
  logic w_tgt_miss;

  // A non-branch predicted taken is a BTB alias and must be undone.
  assign o_act_taken   = i_is_branch & i_taken;
  assign w_dir_miss    = i_pred_taken ^ o_act_taken;
  assign w_tgt_miss    = i_pred_taken & o_act_taken
                       & (i_pred_target != i_target);
  assign o_miss        = w_dir_miss | w_tgt_miss;
  assign o_true_target = o_act_taken ? i_target : pc_seq(i_pc);
  assign o_true_type   = i_is_branch ? i_target_type : _BPU_TARGET_NPC;

endmodule

// File: rtl/bpu_resolve.sv
// Execute-side branch resolution: picks at most one mispredicted lane,
// trains/redirects the predictor and owns the fetch epoch bit.
module bpu_resolve
  import bpu_resolve_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_stall_i,
  input  logic                  excp_flush_i,
  input  logic [1:0]            ex_valid_i,
  input  logic [1:0]            ex_epoch_i,
  input  logic [1:0][31:0]      ex_pc_i,
  input  bpu_predict_t [1:0]    ex_predict_i,
  input  logic [1:0]            ex_is_branch_i,
  input  logic [1:0]            ex_cond_i,
  input  logic [1:0][1:0]       ex_target_type_i,
  input  logic [1:0]            ex_taken_i,
  input  logic [1:0][31:0]      ex_target_i,
  output logic                  epoch_o,
  output logic [1:0]            kill_o,
  output bpu_correct_t          correct_o,
  output logic                  redirect_o,
  output logic [31:0]           redirect_target_o,
  output logic [CNT_W-1:0]      br_cnt_o,
  output logic [CNT_W-1:0]      miss_cnt_o
);

  logic              r_epoch;
  bpu_correct_t      r_correct;
  logic [31:0]       r_redirect_target;
  logic [CNT_W-1:0]  r_br_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [1:0]        w_live;
  logic [1:0]        w_stale;
  logic [1:0]        w_lane_miss;
  logic [1:0]        w_act_taken;
  logic [1:0][31:0]  w_true_target;
  logic [1:0][1:0]   w_true_type;
  logic [1:0]        w_miss;
  logic              w_sel0;
  logic              w_sel1;
  logic              w_fire;
  logic [1:0]        w_br_inc;
  bpu_correct_t      w_pkt;
  logic [CNT_W:0]    w_br_sum;
  logic [CNT_W:0]    w_miss_sum;
  logic [CNT_W-1:0]  w_br_nxt;
  logic [CNT_W-1:0]  w_miss_nxt;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    assign w_live[g] = ex_valid_i[g]
                     & (ex_epoch_i[g] == r_epoch)
                     & ~ex_stall_i & ~excp_flush_i;
    assign w_stale[g] = ex_valid_i[g]
                      & (ex_epoch_i[g] != r_epoch);

    bpu_lane_check u_chk (
      .i_pc          (ex_pc_i[g]),
      .i_pred_taken  (ex_predict_i[g].taken),
      .i_pred_target (ex_predict_i[g].target),
      .i_is_branch   (ex_is_branch_i[g]),
      .i_taken       (ex_taken_i[g]),
      .i_target_type (ex_target_type_i[g]),
      .i_target      (ex_target_i[g]),
      .o_miss        (w_lane_miss[g]),
      .o_act_taken   (w_act_taken[g]),
      .o_true_target (w_true_target[g]),
      .o_true_type   (w_true_type[g])
    );

    assign w_miss[g] = w_live[g] & w_lane_miss[g];
  end

  // The older lane wins; the younger one is on its wrong path.
  assign w_sel0 = w_miss[0];
  assign w_sel1 = ~w_miss[0] & w_miss[1];
  assign w_fire = w_sel0 | w_sel1;

  assign kill_o = {w_stale[1] | w_sel0, w_stale[0]};

  assign w_br_inc = {1'b0, w_live[0] & ex_is_branch_i[0]}
                  + {1'b0, w_live[1] & ex_is_branch_i[1] & ~w_sel0};

  always_comb begin
    w_pkt = '0;
    unique case (1'b1)
      w_sel1: begin
        w_pkt.pc               = ex_pc_i[1];
        w_pkt.true_taken       = w_act_taken[1];
        w_pkt.true_dir         = ex_cond_i[1];
        w_pkt.true_target_type = w_true_type[1];
        w_pkt.true_target      = w_true_target[1];
        w_pkt.history          = ex_predict_i[1].history;
        w_pkt.lphr             = ex_predict_i[1].lphr;
        w_pkt.ras_ptr          = ex_predict_i[1].ras_ptr;
      end
      default: begin
        w_pkt.pc               = ex_pc_i[0];
        w_pkt.true_taken       = w_act_taken[0];
        w_pkt.true_dir         = ex_cond_i[0];
        w_pkt.true_target_type = w_true_type[0];
        w_pkt.true_target      = w_true_target[0];
        w_pkt.history          = ex_predict_i[0].history;
        w_pkt.lphr             = ex_predict_i[0].lphr;
        w_pkt.ras_ptr          = ex_predict_i[0].ras_ptr;
      end
    endcase
    w_pkt.miss = w_fire;
  end

  assign w_br_sum   = {1'b0, r_br_cnt}
                    + {{(CNT_W-1){1'b0}}, w_br_inc};
  assign w_miss_sum = {1'b0, r_miss_cnt}
                    + {{CNT_W{1'b0}}, w_fire};
  assign w_br_nxt   = w_br_sum[CNT_W] ? '1
                    : w_br_sum[CNT_W-1:0];
  assign w_miss_nxt = w_miss_sum[CNT_W] ? '1
                    : w_miss_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_epoch           <= 1'b0;
      r_correct         <= '0;
      r_redirect_target <= '0;
      r_br_cnt          <= '0;
      r_miss_cnt        <= '0;
    end else begin
      r_correct         <= w_fire ? w_pkt : '0;
      r_redirect_target <= w_fire ? w_pkt.true_target : '0;
      if (excp_flush_i | w_fire)
        r_epoch <= ~r_epoch;
      r_br_cnt          <= w_br_nxt;
      r_miss_cnt        <= w_miss_nxt;
    end
  end

  assign epoch_o           = r_epoch;
  assign correct_o         = r_correct;
  assign redirect_o        = r_correct.miss;
  assign redirect_target_o = r_redirect_target;
  assign br_cnt_o          = r_br_cnt;
  assign miss_cnt_o        = r_miss_cnt;

endmodule

// File: tb/tb_bpu_resolve.sv
// Vector table plus scoreboard bench for bpu_resolve (4-bit counters so
// saturation is reachable).
module tb_bpu_resolve;
  import bpu_resolve_pkg::*;

  localparam int CW = 4;
  localparam int CMAX = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ex_stall_i;
  logic                 excp_flush_i;
  logic [1:0]           ex_valid_i;
  logic [1:0]           ex_epoch_i;
  logic [1:0][31:0]     ex_pc_i;
  bpu_predict_t [1:0]   ex_predict_i;
  logic [1:0]           ex_is_branch_i;
  logic [1:0]           ex_cond_i;
  logic [1:0][1:0]      ex_target_type_i;
  logic [1:0]           ex_taken_i;
  logic [1:0][31:0]     ex_target_i;
  logic                 epoch_o;
  logic [1:0]           kill_o;
  bpu_correct_t         correct_o;
  logic                 redirect_o;
  logic [31:0]          redirect_target_o;
  logic [CW-1:0]        br_cnt_o;
  logic [CW-1:0]        miss_cnt_o;

  bpu_resolve #(.CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_stall_i        (ex_stall_i),
    .excp_flush_i      (excp_flush_i),
    .ex_valid_i        (ex_valid_i),
    .ex_epoch_i        (ex_epoch_i),
    .ex_pc_i           (ex_pc_i),
    .ex_predict_i      (ex_predict_i),
    .ex_is_branch_i    (ex_is_branch_i),
    .ex_cond_i         (ex_cond_i),
    .ex_target_type_i  (ex_target_type_i),
    .ex_taken_i        (ex_taken_i),
    .ex_target_i       (ex_target_i),
    .epoch_o           (epoch_o),
    .kill_o            (kill_o),
    .correct_o         (correct_o),
    .redirect_o        (redirect_o),
    .redirect_target_o (redirect_target_o),
    .br_cnt_o          (br_cnt_o),
    .miss_cnt_o        (miss_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        stale;
    logic        br;
    logic        cond;
    logic [1:0]  tt;
    logic        tk;
    logic [31:0] tgt;
    logic        pt;
    logic [31:0] ptgt;
  } lane_t;

  typedef struct {
    logic [31:0] pc0;
    lane_t       l0;
    lane_t       l1;
    logic        stall;
    logic        flush;
    logic [1:0]  xkill;
    logic        xmiss;
    logic        xsel;
    logic [1:0]  xtt;
    logic        xtaken;
    logic        xdir;
    logic [31:0] xtgt;
    logic [1:0]  xbr;
  } vec_t;

  localparam logic [7:0] HIST0 = 8'hA5;
  localparam logic [7:0] HIST1 = 8'h3C;
  localparam logic [1:0] LPHR0 = 2'd1;
  localparam logic [1:0] LPHR1 = 2'd2;
  localparam logic [2:0] RAS0  = 3'd3;
  localparam logic [2:0] RAS1  = 3'd6;

  int    n_tests = 0;
  int    n_fail  = 0;
  logic  e_ep    = 1'b0;
  int    e_br    = 0;
  int    e_miss  = 0;
  vec_t  tv[$];
  vec_t  sb[$];
  lane_t X;

  function automatic lane_t ln(
    input logic v, input logic st, input logic br, input logic c,
    input logic [1:0] tt, input logic tk, input logic [31:0] tg,
    input logic pt, input logic [31:0] ptg);
    lane_t l;
    l.v = v; l.stale = st; l.br = br; l.cond = c; l.tt = tt;
    l.tk = tk; l.tgt = tg; l.pt = pt; l.ptgt = ptg;
    return l;
  endfunction

  function automatic vec_t mk(
    input logic [31:0] pc, input lane_t a, input lane_t b,
    input logic st, input logic fl, input logic [1:0] k,
    input logic m, input logic s, input logic [1:0] tt,
    input logic tk, input logic dr, input logic [31:0] tg,
    input logic [1:0] br);
    vec_t v;
    v.pc0 = pc; v.l0 = a; v.l1 = b; v.stall = st; v.flush = fl;
    v.xkill = k; v.xmiss = m; v.xsel = s; v.xtt = tt;
    v.xtaken = tk; v.xdir = dr; v.xtgt = tg; v.xbr = br;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_lane(input int i, input lane_t l,
                            input logic [31:0] pc);
    ex_valid_i[i]            = l.v;
    ex_epoch_i[i]            = l.stale ? ~e_ep : e_ep;
    ex_pc_i[i]               = pc;
    ex_is_branch_i[i]        = l.br;
    ex_cond_i[i]             = l.cond;
    ex_target_type_i[i]      = l.tt;
    ex_taken_i[i]            = l.tk;
    ex_target_i[i]           = l.tgt;
    ex_predict_i[i].taken    = l.pt;
    ex_predict_i[i].target   = l.ptgt;
    ex_predict_i[i].history  = (i == 0) ? HIST0 : HIST1;
    ex_predict_i[i].lphr     = (i == 0) ? LPHR0 : LPHR1;
    ex_predict_i[i].ras_ptr  = (i == 0) ? RAS0 : RAS1;
  endtask

  task automatic apply(input vec_t v);
    vec_t x;
    @(negedge clk);
    ex_stall_i   = v.stall;
    excp_flush_i = v.flush;
    drive_lane(0, v.l0, v.pc0);
    drive_lane(1, v.l1, v.pc0 + 32'd4);
    sb.push_back(v);
    #1;
    chk("kill", 64'(kill_o), 64'(v.xkill));
    chk("epoch_pre", 64'(epoch_o), 64'(e_ep));
    @(posedge clk);
    #1;
    x = sb.pop_front();
    if (x.xmiss || x.flush) e_ep = ~e_ep;
    e_br = (e_br + int'(x.xbr) > CMAX) ? CMAX : e_br + int'(x.xbr);
    if (x.xmiss) e_miss = (e_miss + 1 > CMAX) ? CMAX : e_miss + 1;
    chk("miss", 64'(correct_o.miss), 64'(x.xmiss));
    chk("redirect", 64'(redirect_o), 64'(x.xmiss));
    chk("epoch", 64'(epoch_o), 64'(e_ep));
    chk("br_cnt", 64'(br_cnt_o), 64'(e_br));
    chk("miss_cnt", 64'(miss_cnt_o), 64'(e_miss));
    if (x.xmiss) begin
      chk("pc", 64'(correct_o.pc), 64'(x.xsel ? x.pc0 + 32'd4 : x.pc0));
      chk("true_target", 64'(correct_o.true_target), 64'(x.xtgt));
      chk("redir_target", 64'(redirect_target_o), 64'(x.xtgt));
      chk("true_type", 64'(correct_o.true_target_type), 64'(x.xtt));
      chk("true_taken", 64'(correct_o.true_taken), 64'(x.xtaken));
      chk("true_dir", 64'(correct_o.true_dir), 64'(x.xdir));
      chk("history", 64'(correct_o.history),
          64'(x.xsel ? HIST1 : HIST0));
      chk("lphr", 64'(correct_o.lphr), 64'(x.xsel ? LPHR1 : LPHR0));
      chk("ras_ptr", 64'(correct_o.ras_ptr), 64'(x.xsel ? RAS1 : RAS0));
    end else begin
      chk("correct_zero", 64'(correct_o), 64'd0);
      chk("redir_tgt_zero", 64'(redirect_target_o), 64'd0);
    end
  endtask

  initial begin
    localparam logic [1:0] N = _BPU_TARGET_NPC;
    localparam logic [1:0] C = _BPU_TARGET_CALL;
    localparam logic [1:0] R = _BPU_TARGET_RETURN;
    localparam logic [1:0] I = _BPU_TARGET_IMM;
    lane_t wp0, wp1, st0, ok0, ok1, ms0;

    X = ln(0, 0, 0, 0, N, 0, 0, 0, 0);
    rst = 1'b1;
    ex_stall_i = 1'b0;
    excp_flush_i = 1'b0;
    drive_lane(0, X, 32'h0);
    drive_lane(1, X, 32'h4);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_epoch", 64'(epoch_o), 64'd0);
    chk("rst_correct", 64'(correct_o), 64'd0);
    chk("rst_redirect", 64'(redirect_o), 64'd0);
    chk("rst_br_cnt", 64'(br_cnt_o), 64'd0);
    chk("rst_miss_cnt", 64'(miss_cnt_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    wp0 = ln(1, 1, 1, 1, I, 1, 32'h500, 0, 0);
    wp1 = ln(1, 1, 1, 0, I, 1, 32'h600, 1, 32'h600);
    st0 = ln(1, 0, 1, 1, I, 0, 0, 1, 32'h680);

    // beq mispredicted taken; lane1 killed
    tv.push_back(mk(32'h1c000100,
      ln(1, 0, 1, 1, I, 0, 0, 1, 32'h1c000200),
      ln(1, 0, 0, 0, N, 0, 0, 0, 0),
      0, 0, 2'b10, 1, 0, I, 0, 1, 32'h1c000104, 2'd1));
    // wrong path in old epoch
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(32'h1c000200, wp0, wp1,
        0, 0, 2'b11, 0, 0, N, 0, 0, 0, 2'd0));
    tv.push_back(mk(32'h1c000104,
      ln(1, 0, 1, 1, I, 1, 32'h1c000400, 1, 32'h1c000400), X,
      0, 0, 2'b00, 0, 0, N, 0, 0, 0, 2'd1));
    // both lanes miss: only lane0 reported
    tv.push_back(mk(32'h100,
      ln(1, 0, 1, 1, I, 1, 32'h300, 0, 0),
      ln(1, 0, 1, 1, I, 0, 0, 1, 32'h400),
      0, 0, 2'b10, 1, 0, I, 1, 1, 32'h300, 2'd1));
    // lane1 return with wrong target
    tv.push_back(mk(32'h200,
      ln(1, 0, 0, 0, N, 0, 0, 0, 0),
      ln(1, 0, 1, 0, R, 1, 32'h90, 1, 32'h80),
      0, 0, 2'b00, 1, 1, R, 1, 0, 32'h90, 2'd1));
    // BTB alias on a non-branch
    tv.push_back(mk(32'h340,
      ln(1, 0, 0, 0, I, 0, 0, 1, 32'h800),
      ln(1, 0, 1, 0, C, 1, 32'h900, 1, 32'h900),
      0, 0, 2'b10, 1, 0, N, 0, 0, 32'h344, 2'd0));
    tv.push_back(mk(32'h400, X,
      ln(1, 0, 1, 0, C, 1, 32'h900, 1, 32'h900),
      0, 0, 2'b00, 0, 0, N, 0, 0, 0, 2'd1));
    tv.push_back(mk(32'h500,
      ln(1, 0, 1, 1, I, 0, 0, 0, 0),
      ln(1, 0, 1, 1, I, 1, 32'h700, 1, 32'h708),
      0, 0, 2'b00, 1, 1, I, 1, 1, 32'h700, 2'd2));
    // stall holds a mispredicted lane
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(32'h600, st0, X,
        1, 0, 2'b00, 0, 0, N, 0, 0, 0, 2'd0));
    tv.push_back(mk(32'h600, st0, X,
      0, 0, 2'b10, 1, 0, I, 0, 1, 32'h604, 2'd1));
    st0.stale = 1'b1;
    tv.push_back(mk(32'h600, st0, X,
      0, 0, 2'b01, 0, 0, N, 0, 0, 0, 2'd0));
    // exception flush beats the miss
    tv.push_back(mk(32'h700,
      ln(1, 0, 1, 1, I, 0, 0, 1, 32'h780), X,
      0, 1, 2'b00, 0, 0, N, 0, 0, 0, 2'd0));
    tv.push_back(mk(32'h800,
      ln(1, 0, 1, 0, I, 1, 32'h880, 1, 32'h880), X,
      0, 0, 2'b00, 0, 0, N, 0, 0, 0, 2'd1));

    foreach (tv[i]) apply(tv[i]);

    // counter saturation
    ok0 = ln(1, 0, 1, 1, I, 0, 0, 0, 0);
    ok1 = ln(1, 0, 1, 1, I, 1, 32'h40, 1, 32'h40);
    for (int i = 0; i < 8; i++)
      apply(mk(32'h900, ok0, ok1,
        0, 0, 2'b00, 0, 0, N, 0, 0, 0, 2'd2));
    ms0 = ln(1, 0, 1, 1, I, 1, 32'h1000, 0, 0);
    for (int i = 0; i < 12; i++)
      apply(mk(32'ha00, ms0, X,
        0, 0, 2'b10, 1, 0, I, 1, 1, 32'h1000, 2'd1));

    // reset while a redirect pulse is visible
    @(negedge clk);
    chk("pulse_before_rst", 64'(redirect_o), 64'd1);
    rst = 1'b1;
    drive_lane(0, X, 32'h0);
    drive_lane(1, X, 32'h4);
    @(posedge clk);
    #1;
    chk("rst2_epoch", 64'(epoch_o), 64'd0);
    chk("rst2_correct", 64'(correct_o), 64'd0);
    chk("rst2_redirect", 64'(redirect_o), 64'd0);
    chk("rst2_redir_tgt", 64'(redirect_target_o), 64'd0);
    chk("rst2_br_cnt", 64'(br_cnt_o), 64'd0);
    chk("rst2_miss_cnt", 64'(miss_cnt_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
